// File: rtl/eda_strobe_scanner.sv
// -----------------------------------------------------------------------------
// eda_strobe_scanner
//
// Reader side of the strobe bitmap. On start it snapshots the M x N strobe
// vector into a shadow register and walks every set bit in raster order
// (row 0 first, lowest column first). Each set pixel is offered as
// {row, col} on a valid/ready handshake and cleared from the shadow once
// accepted. When the shadow is empty a one-cycle iterated_all pulse is issued.
//
// Optional build macro:
//   EDA_STROBE_SCAN_ROW_PIPE_EN - split the priority encode into a row stage
//   (SEARCH) and a column stage (ROWSEL). This adds one cycle to every
//   pixel latency, but the empty-bitmap latency is unchanged.
//
// Ports:
//   clk           clock
//   reset_n       asynchronous active-low reset
//   start         single-cycle pulse: snapshot strb_value and begin a scan
//   clear         synchronous abort back to IDLE (highest priority)
//   strb_value    [M-1:0][N-1:0] strobe bitmap, strb_value[row][col]
//   pix_ready     consumer accepts pix_addr
//   pix_valid     pix_addr holds a pending set pixel
//   pix_addr      {row, col}, column in the low J_WIDTH bits
//   iterated_all  one-cycle pulse when the scan is exhausted
//   busy          high in any state other than IDLE
//   pix_count     pixels accepted in the current scan
// -----------------------------------------------------------------------------
module eda_strobe_scanner #(
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int I_WIDTH    = 3,
    parameter int J_WIDTH    = 3,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         clear,
    input  logic [M-1:0][N-1:0]          strb_value,
    input  logic                         pix_ready,
    output logic                         pix_valid,
    output logic [ADDR_WIDTH-1:0]        pix_addr,
    output logic                         iterated_all,
    output logic                         busy,
    output logic [ADDR_WIDTH:0]          pix_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        VALID,
        DONE
`ifdef EDA_STROBE_SCAN_ROW_PIPE_EN
        , ROWSEL
`endif
    } state_t;

    state_t               state;
    logic [M-1:0][N-1:0]  shadow;
    logic [I_WIDTH-1:0]   row_q;
    logic [J_WIDTH-1:0]   col_q;

    // Lowest-index row containing any set bit (0 when the bitmap is empty).
    function automatic logic [I_WIDTH-1:0] first_row(input logic [M-1:0][N-1:0] bm);
        logic [I_WIDTH-1:0] idx;
        idx = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (|bm[i]) idx = I_WIDTH'(i);
        end
        return idx;
    endfunction

    // Lowest set column within one row (0 when the row is empty).
    function automatic logic [J_WIDTH-1:0] first_col(input logic [N-1:0] row);
        logic [J_WIDTH-1:0] idx;
        idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (row[j]) idx = J_WIDTH'(j);
        end
        return idx;
    endfunction

    logic [I_WIDTH-1:0] srch_row;
    logic [J_WIDTH-1:0] sel_col;

    assign srch_row = first_row(shadow);
`ifdef EDA_STROBE_SCAN_ROW_PIPE_EN
    // Column encode runs on the row registered during SEARCH.
    assign sel_col  = first_col(shadow[row_q]);
`else
    assign sel_col  = first_col(shadow[srch_row]);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shadow       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            pix_valid    <= 1'b0;
            pix_addr     <= '0;
            iterated_all <= 1'b0;
            busy         <= 1'b0;
            pix_count    <= '0;
        end else if (clear) begin
            // Abort wins over start and over a same-cycle handshake;
            // pix_count and pix_addr keep their last values.
            state        <= IDLE;
            shadow       <= '0;
            pix_valid    <= 1'b0;
            iterated_all <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow    <= strb_value;
                        pix_count <= '0;
                        busy      <= 1'b1;
                        state     <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (shadow == '0) begin
                        iterated_all <= 1'b1;
                        state        <= DONE;
                    end else begin
`ifdef EDA_STROBE_SCAN_ROW_PIPE_EN
                        row_q <= srch_row;
                        state <= ROWSEL;
`else
                        row_q     <= srch_row;
                        col_q     <= sel_col;
                        pix_addr  <= {srch_row, sel_col};
                        pix_valid <= 1'b1;
                        state     <= VALID;
`endif
                    end
                end

`ifdef EDA_STROBE_SCAN_ROW_PIPE_EN
                ROWSEL: begin
                    col_q     <= sel_col;
                    pix_addr  <= {row_q, sel_col};
                    pix_valid <= 1'b1;
                    state     <= VALID;
                end
`endif

                VALID: begin
                    // pix_addr stays put until the consumer takes it.
                    if (pix_ready) begin
                        shadow[row_q][col_q] <= 1'b0;
                        pix_count            <= pix_count + (ADDR_WIDTH + 1)'(1);
                        pix_valid            <= 1'b0;
                        state                <= SEARCH;
                    end
                end

                DONE: begin
                    iterated_all <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    pix_valid    <= 1'b0;
                    iterated_all <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eda_strobe_scanner.sv
// -----------------------------------------------------------------------------
// tb_eda_strobe_scanner
//
// Self-checking bench for eda_strobe_scanner at M=N=4. Expected pixel
// addresses are derived from each bitmap and queued when a scan is started;
// they are popped and compared as the scanner hands pixels over. Latencies
// follow the build: 2 cycles by default, 3 with EDA_STROBE_SCAN_ROW_PIPE_EN.
// -----------------------------------------------------------------------------
module tb_eda_strobe_scanner;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int JW = 2;
    localparam int AW = 4;
`ifdef EDA_STROBE_SCAN_ROW_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                clear = 1'b0;
    logic                pix_ready = 1'b0;
    logic [M-1:0][N-1:0] strb = '0;
    logic                pix_valid;
    logic [AW-1:0]       pix_addr;
    logic                iterated_all;
    logic                busy;
    logic [AW:0]         pix_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    eda_strobe_scanner #(
        .M(M), .N(N), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .clear(clear),
        .strb_value(strb),
        .pix_ready(pix_ready),
        .pix_valid(pix_valid),
        .pix_addr(pix_addr),
        .iterated_all(iterated_all),
        .busy(busy),
        .pix_count(pix_count)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Bounded wait for pix_valid; a miss counts as a failed comparison.
    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!pix_valid && k < 10) begin
            tick();
            k++;
        end
        chk(tag, 32'(pix_valid), 1);
    endtask

    // Full scan of one bitmap. stall: cycles to hold pix_ready low on the
    // first pixel. poke: change strb and pulse start on the first pixel.
    task automatic run_scan(input logic [15:0] bm, input int stall, input bit poke);
        int  last, nexp, busy_cycles, stall_left;
        bit  was_valid, done, poked;
        exp_q.delete();
        nexp = 0;
        for (int i = 0; i < 16; i++) begin
            if (bm[i]) begin
                exp_q.push_back(i);
                nexp++;
            end
        end
        strb      = bm;
        pix_ready = 1'b0;
        start     = 1'b1;
        last      = cyc;
        tick();
        start       = 1'b0;
        was_valid   = 1'b0;
        done        = 1'b0;
        poked       = 1'b0;
        busy_cycles = 0;
        stall_left  = stall;
        for (int k = 0; k < 200 && !done; k++) begin
            if (busy) busy_cycles++;
            if (iterated_all) begin
                chk("done_lat", 32'(cyc - last), 32'((nexp == 0) ? 2 : LAT));
                chk("left_over", 32'(exp_q.size()), 0);
                chk("valid_at_done", 32'(pix_valid), 0);
                done = 1'b1;
            end else begin
                if (pix_valid && !was_valid)
                    chk("valid_lat", 32'(cyc - last), 32'(LAT));
                if (pix_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                        pix_ready = 1'b1;
                    end else if (stall_left > 0) begin
                        chk("stall_addr", 32'(pix_addr), 32'(exp_q[0]));
                        stall_left--;
                        pix_ready = 1'b0;
                    end else begin
                        chk("addr", 32'(pix_addr), 32'(exp_q.pop_front()));
                        pix_ready = 1'b1;
                        last      = cyc;
                    end
                    if (poke && !poked) begin
                        strb  = ~bm;
                        start = 1'b1;
                        poked = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                end else begin
                    pix_ready = 1'b0;
                    start     = 1'b0;
                end
                was_valid = pix_valid;
                tick();
            end
        end
        if (!done) chk("scan_timeout", 0, 1);
        pix_ready = 1'b0;
        start     = 1'b0;
        chk("pix_count", 32'(pix_count), 32'(nexp));
        if (nexp == 0) chk("busy_cycles", 32'(busy_cycles), 2);
        tick();
        chk("iter_pulse_width", 32'(iterated_all), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("count_hold", 32'(pix_count), 32'(nexp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_valid", 32'(pix_valid), 0);
        chk("rst_addr", 32'(pix_addr), 0);
        chk("rst_iter", 32'(iterated_all), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(pix_count), 0);
        reset_n = 1'b1;
        tick();

        // Sparse bitmap: (0,0),(1,3),(3,2) -> 0x0, 0x7, 0xE
        run_scan(16'h4081, 0, 1'b0);
        // Empty bitmap
        run_scan(16'h0000, 0, 1'b0);
        // Full bitmap: 0x0..0xF, count 16
        run_scan(16'hFFFF, 0, 1'b0);
        // Backpressure: (2,1),(2,2) with 5 stalled cycles on 0x9
        run_scan(16'h0600, 5, 1'b0);
        // Snapshot isolation: strb change and start during VALID ignored
        run_scan(16'h1234, 0, 1'b1);

        // Clear on the second pixel together with pix_ready
        strb  = 16'h4081;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("clr_first_valid");
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        wait_valid("clr_second_valid");
        chk("clr_second_addr", 32'(pix_addr), 7);
        clear     = 1'b1;
        pix_ready = 1'b1;
        tick();
        clear     = 1'b0;
        pix_ready = 1'b0;
        chk("clr_valid", 32'(pix_valid), 0);
        chk("clr_busy", 32'(busy), 0);
        chk("clr_count", 32'(pix_count), 1);
        chk("clr_addr_hold", 32'(pix_addr), 7);
        for (int k = 0; k < 4; k++) begin
            chk("clr_no_iter", 32'(iterated_all), 0);
            chk("clr_stays_idle", 32'(pix_valid), 0);
            tick();
        end
        // Re-start scans from the lowest set bit again
        run_scan(16'h4081, 0, 1'b0);

        // Asynchronous reset in the middle of a scan
        strb      = 16'hFFFF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        pix_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("pre_rst_count_nonzero", 32'(pix_count != 0), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(pix_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_count", 32'(pix_count), 0);
        chk("async_rst_addr", 32'(pix_addr), 0);
        pix_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy), 0);
        run_scan(16'h8001, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
